// File: rtl/crc_checker.sv
// crc_checker -- receive-side serial CRC checker.
//
// Recomputes the CRC over the payload bits of a serial frame with the same
// Galois LFSR as the serial generator, then compares the W received CRC bits
// (LSB first) against the computed remainder one bit at a time.
//
// Ports:
//   CLK         in   clock, all logic on the rising edge
//   RST         in   synchronous, active-high reset
//   DATA        in   serial payload / CRC bit, LSB first
//   ACTIVE      in   DATA is a payload bit this cycle
//   CRC_VLD_IN  in   DATA is a received CRC bit this cycle
//   BUSY        out  frame in progress (state != IDLE)
//   CHK_DONE    out  one-cycle pulse, check result valid
//   CRC_OK      out  held: last completed frame matched
//   CRC_ERR     out  held: last completed frame mismatched or truncated
//   ERR_CNT     out  saturating failed-frame count (only with CRC_ERR_CNT_EN)
//
// Build option: define CRC_ERR_CNT_EN to add the ERR_CNT port and counter.
module crc_checker #(
    parameter int unsigned    W    = 8,
    parameter logic [W-1:0]   SEED = 8'hD8,
    parameter logic [W-1:0]   TAPS = 8'b0100_0100
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       DATA,
    input  logic       ACTIVE,
    input  logic       CRC_VLD_IN,
    output logic       BUSY,
    output logic       CHK_DONE,
    output logic       CRC_OK,
    output logic       CRC_ERR
`ifdef CRC_ERR_CNT_EN
    ,
    output logic [7:0] ERR_CNT
`endif
);

    localparam int unsigned CW = $clog2(W + 1);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_WAIT_CRC,
        ST_CHECK,
        ST_DONE
    } state_t;

    state_t         state_q, state_d;
    logic [W-1:0]   lfsr_q, lfsr_d;
    logic [CW-1:0]  bit_cnt_q, bit_cnt_d;
    logic           mismatch_q, mismatch_d;
    logic           ok_q, ok_d;
    logic           err_q, err_d;

    // Compare-step results, shared by every state that can accept a CRC bit.
    logic [W-1:0]   cmp_lfsr;
    logic [CW-1:0]  cmp_cnt;
    logic           cmp_mis;
    state_t         cmp_next;

    function automatic logic [W-1:0] lfsr_step(input logic [W-1:0] cur, input logic din);
        logic         fb;
        logic [W-1:0] nxt;
        fb       = din ^ cur[0];
        nxt      = '0;
        nxt[W-1] = fb;
        for (int unsigned i = 0; i < W - 1; i++) begin
            nxt[i] = cur[i+1] ^ (TAPS[i] & fb);
        end
        return nxt;
    endfunction

    always_comb begin
        cmp_lfsr = {1'b0, lfsr_q[W-1:1]};
        cmp_mis  = mismatch_q | (DATA ^ lfsr_q[0]);
        cmp_cnt  = bit_cnt_q + 1'b1;
        // bit_cnt is zero outside CHECK, so this also covers W == 1.
        cmp_next = (bit_cnt_q == LAST) ? ST_DONE : ST_CHECK;
    end

    always_comb begin
        state_d    = state_q;
        lfsr_d     = lfsr_q;
        bit_cnt_d  = bit_cnt_q;
        mismatch_d = mismatch_q;
        ok_d       = ok_q;
        err_d      = err_q;

        case (state_q)
            ST_IDLE: begin
                if (ACTIVE) begin
                    lfsr_d  = lfsr_step(SEED, DATA);
                    state_d = ST_DATA;
                end else if (CRC_VLD_IN) begin
                    // Zero-length frame: received CRC is checked against SEED.
                    lfsr_d     = cmp_lfsr;
                    mismatch_d = cmp_mis;
                    bit_cnt_d  = cmp_cnt;
                    state_d    = cmp_next;
                end
            end
            ST_DATA: begin
                if (ACTIVE) begin
                    lfsr_d = lfsr_step(lfsr_q, DATA);
                end else if (CRC_VLD_IN) begin
                    lfsr_d     = cmp_lfsr;
                    mismatch_d = cmp_mis;
                    bit_cnt_d  = cmp_cnt;
                    state_d    = cmp_next;
                end else begin
                    state_d = ST_WAIT_CRC;
                end
            end
            ST_WAIT_CRC: begin
                if (ACTIVE) begin
                    // New payload after a gap restarts the frame.
                    lfsr_d  = lfsr_step(SEED, DATA);
                    state_d = ST_DATA;
                end else if (CRC_VLD_IN) begin
                    lfsr_d     = cmp_lfsr;
                    mismatch_d = cmp_mis;
                    bit_cnt_d  = cmp_cnt;
                    state_d    = cmp_next;
                end
            end
            ST_CHECK: begin
                if (ACTIVE) begin
                    // Abort: the payload bit starts a fresh frame, no result.
                    lfsr_d     = lfsr_step(SEED, DATA);
                    mismatch_d = 1'b0;
                    bit_cnt_d  = '0;
                    state_d    = ST_DATA;
                end else if (CRC_VLD_IN) begin
                    lfsr_d     = cmp_lfsr;
                    mismatch_d = cmp_mis;
                    bit_cnt_d  = cmp_cnt;
                    state_d    = cmp_next;
                end else begin
                    // Truncated CRC field.
                    mismatch_d = 1'b1;
                    state_d    = ST_DONE;
                end
            end
            ST_DONE: begin
                lfsr_d     = SEED;
                bit_cnt_d  = '0;
                mismatch_d = 1'b0;
                state_d    = ST_IDLE;
            end
            default: begin
                lfsr_d     = SEED;
                bit_cnt_d  = '0;
                mismatch_d = 1'b0;
                state_d    = ST_IDLE;
            end
        endcase

        // Result flags load on the edge into DONE so they are valid with CHK_DONE.
        if (state_d == ST_DONE && state_q != ST_DONE) begin
            ok_d  = ~mismatch_d;
            err_d = mismatch_d;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            lfsr_q     <= SEED;
            bit_cnt_q  <= '0;
            mismatch_q <= 1'b0;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            lfsr_q     <= lfsr_d;
            bit_cnt_q  <= bit_cnt_d;
            mismatch_q <= mismatch_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
        end
    end

    assign BUSY     = (state_q != ST_IDLE);
    assign CHK_DONE = (state_q == ST_DONE);
    assign CRC_OK   = ok_q;
    assign CRC_ERR  = err_q;

`ifdef CRC_ERR_CNT_EN
    logic [7:0] err_cnt_q, err_cnt_d;

    always_comb begin
        err_cnt_d = err_cnt_q;
        if (state_d == ST_DONE && state_q != ST_DONE && mismatch_d && err_cnt_q != 8'hFF) begin
            err_cnt_d = err_cnt_q + 8'd1;
        end
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            err_cnt_q <= '0;
        end else begin
            err_cnt_q <= err_cnt_d;
        end
    end

    assign ERR_CNT = err_cnt_q;
`else
    // No failed-frame counter in this build.
`endif

endmodule
